fft_result_streamer: RTL and testbench
======================================

FFT_RESULT_STREAMER -- requirements
Module: fft_result_streamer

Interface
REQ-001 Parameter N_LOG2, default 5: log2 of FFT length; memory address width.
REQ-002 Parameter DATA_W, default 64: word width, {re[DATA_W-1:DATA_W/2], im[DATA_W/2-1:0]}.
REQ-003 Parameter READ_LAT, default 1: result-memory read latency in clk cycles, range 1..2.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 clr  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  single-cycle pulse: begin unloading FFT result memory.
REQ-007 mem_address  out  N_LOG2  read address to FFT result memory.
REQ-008 mem_data  in  DATA_W  read data, valid READ_LAT cycles after mem_address.
REQ-009 out_data  out  DATA_W  result word in natural frequency order.
REQ-010 out_index  out  N_LOG2  natural-order bin index k of out_data.
REQ-011 out_valid  out  1  out_data/out_index valid.
REQ-012 out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
REQ-013 busy  out  1  unload in progress.
REQ-014 done  out  1  single-cycle pulse after last word transferred.

Function
REQ-015 FSM states IDLE, READ, DRAIN, FINISH; reset state IDLE.
REQ-016 IDLE -> READ on start; rd_count and xfer_count cleared to 0.
REQ-017 In READ, rd_count k yields mem_address = bit-reverse(k) over N_LOG2 bits (k=1 -> 16 for N_LOG2=5).
REQ-018 A read issues (rd_count increments) only when fifo_occupancy + reads_in_flight < FIFO_DEPTH (4); otherwise mem_address holds.
REQ-019 Each returned mem_data is captured into the output FIFO exactly READ_LAT cycles after issue, tagged with its k.
REQ-020 READ -> DRAIN in the cycle the read with k = 2^N_LOG2-1 issues.
REQ-021 DRAIN -> FINISH when the 2^N_LOG2-th transfer completes; FINISH lasts one cycle with done=1, then IDLE.
REQ-022 out_valid = FIFO not empty; head stable while out_valid & ~out_ready.
REQ-023 Simultaneous FIFO push and pop in one cycle leaves occupancy unchanged; no word lost or duplicated.
REQ-024 Sustained out_ready=1: throughput one word per cycle; first out_valid READ_LAT+1 cycles after start.
REQ-025 start while busy=1 ignored; start in the FINISH cycle ignored.
REQ-026 busy = 1 in READ and DRAIN, 0 in IDLE and FINISH.
REQ-027 Counters N_LOG2+1 bits wide; no wrap during an unload.

Reset
REQ-028 clr asserted at any time, including mid-unload, forces IDLE immediately, empties FIFO, discards in-flight reads.
REQ-029 Reset values: mem_address=0, out_data=0, out_index=0, out_valid=0, busy=0, done=0.
REQ-030 First start after clr deassertion behaves as REQ-016.

Structure
REQ-031 Shared package fft_pkg holds N_LOG2, DATA_W, FIFO_DEPTH=4, FSM state encodings, and bit-reverse function.
REQ-032 One sub-module, result_fifo: 4-entry, DATA_W+N_LOG2 wide, synchronous push/pop, async clr, full/empty/count outputs.

Verification
REQ-033 Memory preloaded word[a]=a; start, out_ready=1 -> 32 transfers, out_index 0..31, out_data[k]=bitrev5(k), done one cycle after 32nd transfer.
REQ-034 out_ready=0 for 20 cycles after start -> occupancy 4, mem_address stalls, out_data index 0 held; release -> all 32 delivered in order.
REQ-035 out_ready toggled 1/0 each cycle, READ_LAT=2 -> 32 words, no loss/duplicate, each index once.
REQ-036 clr pulse after 10th transfer -> out_valid=0, busy=0 same cycle; new start -> full sequence from index 0.
REQ-037 Second start at transfer 5 -> ignored; exactly 32 transfers, one done pulse.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and bit-reverse helper for the
// FFT result streamer.
package fft_pkg;

   localparam int N_LOG2     = 5;
   localparam int DATA_W     = 64;
   localparam int FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } state_e;

   // Reverse the low n bits of v; upper bits of the result are zero.
   function automatic logic [31:0] bitrev(
      input logic [31:0] v,
      input int unsigned n
   );
      logic [31:0] r;
      r = {<<{v}};
      return r >> (32 - n);
   endfunction

endpackage

// File: rtl/fft_result_streamer_fifo.sv
// Small first-word-fall-through FIFO holding tagged result words
// between the memory read pipeline and the consumer.
module result_fifo #(
   parameter int W     = 69,
   parameter int DEPTH = fft_pkg::FIFO_DEPTH
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic                       push_i,
   input  logic [W-1:0]               push_data_i,
   input  logic                       pop_i,
   output logic [W-1:0]               pop_data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0][W-1:0] mem_q;
   logic [AW-1:0]           wr_q;
   logic [AW-1:0]           rd_q;
   logic [CW-1:0]           cnt_q;
   logic                    do_push;
   logic                    do_pop;

   assign full_o     = (cnt_q == CW'(DEPTH));
   assign empty_o    = (cnt_q == '0);
   assign count_o    = cnt_q;
   assign pop_data_o = mem_q[rd_q];

   assign do_pop  = pop_i & ~empty_o;
   // A pop frees the head slot in the same cycle, so a full FIFO may
   // still accept a push alongside it.
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         mem_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= push_data_i;
            wr_q        <= wr_q + AW'(1);
         end
         if (do_pop) begin
            rd_q <= rd_q + AW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/fft_result_streamer.sv
// Unloads a bit-reversed FFT result memory and streams the words out
// in natural frequency order over a valid/ready interface.
module fft_result_streamer #(
   parameter int N_LOG2   = fft_pkg::N_LOG2,
   parameter int DATA_W   = fft_pkg::DATA_W,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   output logic [N_LOG2-1:0] mem_address,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] out_data,
   output logic [N_LOG2-1:0] out_index,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   import fft_pkg::*;

   localparam int CW = N_LOG2 + 1;
   localparam int NW = 1 << N_LOG2;
   localparam int EW = DATA_W + N_LOG2;
   localparam int OW = $clog2(FIFO_DEPTH + 1);
   localparam int UW = OW + 1;

   state_e                          state_q;
   logic [CW-1:0]                   rd_count_q;
   logic [CW-1:0]                   xfer_count_q;
   logic                            busy_q;
   logic                            done_q;
   logic [READ_LAT-1:0]             pv_q;
   logic [READ_LAT-1:0][N_LOG2-1:0] pk_q;

   logic [OW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   logic [EW-1:0] head;
   logic [UW-1:0] in_flight;
   logic          issue;
   logic          push;
   logic          pop;

   always_comb begin
      in_flight = '0;
      for (int i = 0; i < READ_LAT; i++) begin
         in_flight = in_flight + UW'(pv_q[i]);
      end
   end

   // Reads in flight reserve a FIFO slot so returning data never overflows.
   assign issue = (state_q == READ) & ~fifo_full &
                  (({1'b0, fifo_count} + in_flight) < UW'(FIFO_DEPTH));
   assign push  = pv_q[READ_LAT-1];
   assign pop   = ~fifo_empty & out_ready;

   assign mem_address =
      N_LOG2'(bitrev(32'(rd_count_q[N_LOG2-1:0]), N_LOG2));

   assign out_valid = ~fifo_empty;
   assign out_data  = head[DATA_W-1:0];
   assign out_index = head[EW-1:DATA_W];
   assign busy      = busy_q;
   assign done      = done_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         pv_q <= '0;
         pk_q <= '0;
      end else begin
         pv_q[0] <= issue;
         pk_q[0] <= rd_count_q[N_LOG2-1:0];
         for (int i = 1; i < READ_LAT; i++) begin
            pv_q[i] <= pv_q[i-1];
            pk_q[i] <= pk_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q      <= IDLE;
         rd_count_q   <= '0;
         xfer_count_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (issue) begin
            rd_count_q <= rd_count_q + CW'(1);
         end
         if (pop) begin
            xfer_count_q <= xfer_count_q + CW'(1);
         end
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q      <= READ;
                  rd_count_q   <= '0;
                  xfer_count_q <= '0;
                  busy_q       <= 1'b1;
               end
            end
            READ: begin
               if (issue && rd_count_q == CW'(NW - 1)) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && xfer_count_q == CW'(NW - 1)) begin
                  state_q <= FINISH;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            FINISH: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   result_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .clr         (clr),
      .push_i      (push),
      .push_data_i ({pk_q[READ_LAT-1], mem_data}),
      .pop_i       (pop),
      .pop_data_o  (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

endmodule

// File: tb/tb_fft_result_streamer.sv
// Directed bench for fft_result_streamer: one instance per read latency,
// natural-order scoreboard per instance.
module tb_fft_result_streamer;

   localparam int NL = 5;
   localparam int DW = 64;
   localparam int NW = 32;

   logic          clk = 1'b0;
   logic          clr;
   logic          start;
   logic          out_ready;
   logic [NL-1:0] ma1, ma2, oi1, oi2;
   logic [DW-1:0] md1, md2, od1, od2, p2;
   logic          ov1, ov2, bz1, bz2, dn1, dn2;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int s_cyc  = 0;
   int xfers[2];
   int done_cnt[2];
   int done_cyc[2];
   int first_v[2];
   int last_x[2];
   bit seen_v[2];
   logic [NL+DW-1:0] sb1[$];
   logic [NL+DW-1:0] sb2[$];

   always #5 clk = ~clk;

   fft_result_streamer #(.N_LOG2(NL), .DATA_W(DW), .READ_LAT(1)) dut1 (
      .clk(clk), .clr(clr), .start(start), .mem_address(ma1),
      .mem_data(md1), .out_data(od1), .out_index(oi1),
      .out_valid(ov1), .out_ready(out_ready), .busy(bz1), .done(dn1)
   );

   fft_result_streamer #(.N_LOG2(NL), .DATA_W(DW), .READ_LAT(2)) dut2 (
      .clk(clk), .clr(clr), .start(start), .mem_address(ma2),
      .mem_data(md2), .out_data(od2), .out_index(oi2),
      .out_valid(ov2), .out_ready(out_ready), .busy(bz2), .done(dn2)
   );

   // Result memories preloaded with word[a] = a.
   always @(posedge clk) begin
      md1 <= DW'(ma1);
      p2  <= DW'(ma2);
      md2 <= p2;
   end

   function automatic logic [NL-1:0] br5(input int k);
      logic [NL-1:0] r;
      for (int i = 0; i < NL; i++) r[i] = k[NL-1-i];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic observe(input int d, input logic v, input logic [NL-1:0] idx,
                          input logic [DW-1:0] dat, input logic dn);
      logic [NL+DW-1:0] e;
      if (v && !seen_v[d]) begin
         seen_v[d]  = 1'b1;
         first_v[d] = cyc;
      end
      if (v && out_ready) begin
         e = 'x;
         if (d == 0 && sb1.size() != 0) e = sb1.pop_front();
         if (d == 1 && sb2.size() != 0) e = sb2.pop_front();
         chk($sformatf("L%0d_index", d + 1), 64'(idx), 64'(e[NL+DW-1:DW]));
         chk($sformatf("L%0d_data", d + 1), dat, e[DW-1:0]);
         last_x[d] = cyc;
         xfers[d]++;
      end
      if (dn) begin
         done_cnt[d]++;
         done_cyc[d] = cyc;
         chk($sformatf("L%0d_done_after_last", d + 1), 64'(cyc),
             64'(last_x[d] + 1));
      end
   endtask

   task automatic step();
      @(negedge clk);
      observe(0, ov1, oi1, od1, dn1);
      observe(1, ov2, oi2, od2, dn2);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic go();
      for (int d = 0; d < 2; d++) begin
         xfers[d]    = 0;
         done_cnt[d] = 0;
         done_cyc[d] = -1;
         seen_v[d]   = 1'b0;
         first_v[d]  = -1;
         last_x[d]   = -100;
      end
      for (int k = 0; k < NW; k++) begin
         sb1.push_back({NL'(k), DW'(br5(k))});
         sb2.push_back({NL'(k), DW'(br5(k))});
      end
      start = 1'b1;
      step();
      start = 1'b0;
      s_cyc = cyc;
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (done_cnt[0] > 0 && done_cnt[1] > 0) break;
         step();
      end
      repeat (4) step();
      chk({tag, "_done_L1"}, 64'(done_cnt[0]), 64'd1);
      chk({tag, "_done_L2"}, 64'(done_cnt[1]), 64'd1);
      chk({tag, "_xfers_L1"}, 64'(xfers[0]), 64'(NW));
      chk({tag, "_xfers_L2"}, 64'(xfers[1]), 64'(NW));
      chk({tag, "_sb_left_L1"}, 64'(sb1.size()), 64'd0);
      chk({tag, "_sb_left_L2"}, 64'(sb2.size()), 64'd0);
      chk({tag, "_busy_L1"}, 64'(bz1), 64'd0);
      chk({tag, "_busy_L2"}, 64'(bz2), 64'd0);
   endtask

   initial begin
      clr       = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("rst_addr_L1", 64'(ma1), 64'd0);
      chk("rst_addr_L2", 64'(ma2), 64'd0);
      chk("rst_data_L1", od1, 64'd0);
      chk("rst_data_L2", od2, 64'd0);
      chk("rst_index_L1", 64'(oi1), 64'd0);
      chk("rst_index_L2", 64'(oi2), 64'd0);
      chk("rst_valid", 64'({ov1, ov2}), 64'd0);
      chk("rst_busy", 64'({bz1, bz2}), 64'd0);
      chk("rst_done", 64'({dn1, dn2}), 64'd0);
      step();
      step();
      clr = 1'b0;
      step();

      // Sustained ready: natural order, latency and throughput.
      out_ready = 1'b1;
      go();
      chk("a_busy", 64'({bz1, bz2}), 64'b11);
      wait_done("a", 100);
      chk("a_first_valid_L1", 64'(first_v[0] - s_cyc), 64'd2);
      chk("a_first_valid_L2", 64'(first_v[1] - s_cyc), 64'd3);
      chk("a_done_lat_L1", 64'(done_cyc[0] - s_cyc), 64'd34);
      chk("a_done_lat_L2", 64'(done_cyc[1] - s_cyc), 64'd35);

      // Consumer stalled: FIFO fills and reads stall at k = 4.
      out_ready = 1'b0;
      go();
      repeat (20) step();
      chk("b_addr_L1", 64'(ma1), 64'(br5(4)));
      chk("b_addr_L2", 64'(ma2), 64'(br5(4)));
      chk("b_valid", 64'({ov1, ov2}), 64'b11);
      chk("b_head_index", 64'({oi1, oi2}), 64'd0);
      chk("b_head_data_L1", od1, 64'(br5(0)));
      chk("b_head_data_L2", od2, 64'(br5(0)));
      repeat (2) step();
      chk("b_addr_hold_L1", 64'(ma1), 64'(br5(4)));
      chk("b_addr_hold_L2", 64'(ma2), 64'(br5(4)));
      chk("b_busy", 64'({bz1, bz2}), 64'b11);
      out_ready = 1'b1;
      wait_done("b", 100);

      // Ready toggling every cycle.
      go();
      for (int i = 0; i < 300; i++) begin
         if (done_cnt[0] > 0 && done_cnt[1] > 0) break;
         out_ready = ~out_ready;
         step();
      end
      out_ready = 1'b1;
      wait_done("c", 10);

      // Clear mid-unload after the 10th transfer, then a fresh unload.
      go();
      for (int i = 0; i < 100; i++) begin
         if (xfers[0] >= 10) break;
         step();
      end
      chk("d_reached_10", 64'(xfers[0]), 64'd10);
      clr = 1'b1;
      #1;
      chk("d_clr_valid", 64'({ov1, ov2}), 64'd0);
      chk("d_clr_busy", 64'({bz1, bz2}), 64'd0);
      chk("d_clr_addr", 64'({ma1, ma2}), 64'd0);
      sb1.delete();
      sb2.delete();
      step();
      clr = 1'b0;
      step();
      go();
      wait_done("d", 100);

      // Second start during an unload is ignored.
      go();
      for (int i = 0; i < 100; i++) begin
         if (xfers[0] >= 5) break;
         step();
      end
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done("e", 100);

      // Start landing in the FINISH cycle is ignored.
      go();
      for (int i = 0; i < 100; i++) begin
         if (dn1) break;
         step();
      end
      chk("f_in_finish", 64'(dn1), 64'd1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("f_no_restart", 64'(bz1), 64'd0);
      wait_done("f", 100);
      chk("f_idle_valid", 64'({ov1, ov2}), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
